// File: rtl/walk_service_controller.sv
// walk_service_controller
//
// Reader side of the pedestrian walk request latch. Samples the latched
// request level, asks the main traffic FSM for the crossing phase, runs the
// steady walk / flashing don't-walk sequence from a 1 Hz tick enable, and
// pulses WR_Reset for one cycle on walk grant to clear the request latch.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Tick         in   one-Clk-wide enable, once per second
//   WR           in   latched walk request level
//   Phase_Grant  in   main FSM holds main road red, crossing permitted
//   Walk_Busy    out  registered; request to enter/hold the crossing phase
//   Walk         out  registered; steady walk lamp
//   Dont_Walk    out  registered; don't-walk lamp (steady or flashing)
//   WR_Reset     out  registered; one-cycle clear pulse to the request latch
//   o_dbg_state  out  current FSM state, for observation only
//
// Handshake with the main FSM: Walk_Busy is the request and Phase_Grant the
// grant. Walk_Busy rises on WAIT_GRANT entry and stays high until CLEAR
// entry; the walk starts only on a cycle where both are high. Once the walk
// has started the grant is no longer sampled, so the sequence always
// completes, and the main FSM is released only by Walk_Busy falling.

module walk_service_controller #(
  parameter int WALK_SEC  = 7,
  parameter int FLASH_SEC = 5,
  parameter int CNT_W     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       WR,
  input  logic       Phase_Grant,
  output logic       Walk_Busy,
  output logic       Walk,
  output logic       Dont_Walk,
  output logic       WR_Reset,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_GRANT = 3'd1,
    S_WALK       = 3'd2,
    S_FLASH      = 3'd3,
    S_CLEAR      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  // High during the first cycle spent in WALK or FLASH; a Tick seen there
  // is ignored so every phase gets its full count of later Ticks.
  logic             r_first;
  logic             w_next_first;
  logic             w_tick;
  logic             w_next_busy;
  logic             w_next_walk;
  logic             w_next_dont_walk;
  logic             w_next_wr_reset;

  assign w_tick      = Tick && !r_first;
  assign o_dbg_state = r_state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      Walk_Busy <= 1'b0;
      Walk      <= 1'b0;
      Dont_Walk <= 1'b1;
      WR_Reset  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_first   <= w_next_first;
      Walk_Busy <= w_next_busy;
      Walk      <= w_next_walk;
      Dont_Walk <= w_next_dont_walk;
      WR_Reset  <= w_next_wr_reset;
    end
  end

  // Next state and counter.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (WR) w_next_state = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (Phase_Grant) begin
          w_next_state = S_WALK;
          w_next_cnt   = CNT_W'(WALK_SEC);
        end
      end
      S_WALK: begin
        if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = S_FLASH;
            w_next_cnt   = CNT_W'(FLASH_SEC);
          end else if (r_cnt != '0) begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      S_FLASH: begin
        if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = S_CLEAR;
            w_next_cnt   = '0;
          end else if (r_cnt != '0) begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      S_CLEAR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so outputs change on state entry.
  always_comb begin
    w_next_busy      = 1'b0;
    w_next_walk      = 1'b0;
    w_next_dont_walk = 1'b1;
    w_next_wr_reset  = 1'b0;
    w_next_first     = 1'b0;
    case (w_next_state)
      S_WAIT_GRANT: begin
        w_next_busy = 1'b1;
      end
      S_WALK: begin
        w_next_busy      = 1'b1;
        w_next_walk      = 1'b1;
        w_next_dont_walk = 1'b0;
        w_next_wr_reset  = (r_state == S_WAIT_GRANT);
        w_next_first     = (r_state != S_WALK);
      end
      S_FLASH: begin
        w_next_busy  = 1'b1;
        w_next_first = (r_state != S_FLASH);
        // Lamp starts high on entry, then flips on every counted Tick.
        if (r_state == S_FLASH) begin
          w_next_dont_walk = w_tick ? !Dont_Walk : Dont_Walk;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_walk_service_controller.sv
// tb_walk_service_controller
//
// Directed bench for walk_service_controller. A phase/tick-count model of
// the walk sequence predicts every output each cycle; monitor counters plus
// hand-computed literal values pin the model for each scenario.

module tb_walk_service_controller;

  localparam int WALK_SEC  = 7;
  localparam int FLASH_SEC = 5;
  localparam int CNT_W     = 4;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_WALK  = 2;
  localparam int P_FLASH = 3;
  localparam int P_CLEAR = 4;

  // ---------------- clock / reset ----------------
  logic       Clk         = 1'b0;
  logic       Reset       = 1'b1;
  logic       Tick        = 1'b0;
  logic       WR          = 1'b0;
  logic       Phase_Grant = 1'b0;
  logic       Walk_Busy;
  logic       Walk;
  logic       Dont_Walk;
  logic       WR_Reset;
  logic [2:0] dbg_state;

  always #5 Clk = ~Clk;

  walk_service_controller #(
    .WALK_SEC (WALK_SEC),
    .FLASH_SEC(FLASH_SEC),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (Tick),
    .WR         (WR),
    .Phase_Grant(Phase_Grant),
    .Walk_Busy  (Walk_Busy),
    .Walk       (Walk),
    .Dont_Walk  (Dont_Walk),
    .WR_Reset   (WR_Reset),
    .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // Tracks which phase the crossing is in and how many Ticks that phase has
  // consumed; lamps follow from phase and tick parity.
  int   m_phase = P_IDLE;
  int   m_ticks = 0;
  logic m_first = 1'b0;
  logic m_wrr   = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_phase <= P_IDLE;
      m_ticks <= 0;
      m_first <= 1'b0;
      m_wrr   <= 1'b0;
    end else begin
      m_wrr <= 1'b0;
      case (m_phase)
        P_IDLE: if (WR) m_phase <= P_WAIT;
        P_WAIT: if (Phase_Grant) begin
          m_phase <= P_WALK; m_ticks <= 0; m_first <= 1'b1; m_wrr <= 1'b1;
        end
        P_WALK: begin
          if (m_first) m_first <= 1'b0;
          else if (Tick) begin
            if (m_ticks + 1 == WALK_SEC) begin
              m_phase <= P_FLASH; m_ticks <= 0; m_first <= 1'b1;
            end else m_ticks <= m_ticks + 1;
          end
        end
        P_FLASH: begin
          if (m_first) m_first <= 1'b0;
          else if (Tick) begin
            if (m_ticks + 1 == FLASH_SEC) begin
              m_phase <= P_CLEAR; m_ticks <= 0;
            end else m_ticks <= m_ticks + 1;
          end
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // ---------------- monitor counters ----------------
  int   mon_walk_cyc  = 0;
  int   mon_busy_cyc  = 0;
  int   mon_wrr       = 0;
  int   mon_dw_fall   = 0;
  int   mon_walk_rise = 0;
  int   mon_busy_fall = 0;
  int   mon_walk_tick = 0;
  int   mon_flash_tick = 0;
  logic prev_dw   = 1'b1;
  logic prev_walk = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge Clk) begin
    if (Walk) mon_walk_cyc <= mon_walk_cyc + 1;
    if (Walk_Busy) mon_busy_cyc <= mon_busy_cyc + 1;
    if (WR_Reset) mon_wrr <= mon_wrr + 1;
    if (prev_dw && !Dont_Walk) mon_dw_fall <= mon_dw_fall + 1;
    if (!prev_walk && Walk) mon_walk_rise <= mon_walk_rise + 1;
    if (prev_busy && !Walk_Busy) mon_busy_fall <= mon_busy_fall + 1;
    if (Tick && Walk) mon_walk_tick <= mon_walk_tick + 1;
    if (Tick && Walk_Busy && !Walk) mon_flash_tick <= mon_flash_tick + 1;
    prev_dw   <= Dont_Walk;
    prev_walk <= Walk;
    prev_busy <= Walk_Busy;
  end

  int s_walk_cyc, s_busy_cyc, s_wrr, s_dw_fall, s_walk_rise, s_busy_fall;
  int s_walk_tick, s_flash_tick;

  task automatic snap();
    s_walk_cyc   = mon_walk_cyc;
    s_busy_cyc   = mon_busy_cyc;
    s_wrr        = mon_wrr;
    s_dw_fall    = mon_dw_fall;
    s_walk_rise  = mon_walk_rise;
    s_busy_fall  = mon_busy_fall;
    s_walk_tick  = mon_walk_tick;
    s_flash_tick = mon_flash_tick;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic e_dw;
    e_dw = !(m_phase == P_WALK) && !(m_phase == P_FLASH && (m_ticks % 2) == 1);
    check("model_busy", int'(Walk_Busy),
          int'(m_phase == P_WAIT || m_phase == P_WALK || m_phase == P_FLASH));
    check("model_walk", int'(Walk), int'(m_phase == P_WALK));
    check("model_dont_walk", int'(Dont_Walk), int'(e_dw));
    check("model_wr_reset", int'(WR_Reset), int'(m_wrr));
  endtask

  // ---------------- drivers ----------------
  // Inputs are applied, outputs compared against the model at the falling
  // edge, then one rising edge consumes the inputs. Returns 2 units after it.
  task automatic step(input logic wr, input logic pg, input logic tk);
    WR = wr; Phase_Grant = pg; Tick = tk;
    @(negedge Clk);
    cmp_model();
    @(posedge Clk);
    #2;
  endtask

  task automatic run_ticks(input int n, input logic wr, input logic pg,
                           input int period, input int offset);
    for (int k = 0; k < n; k++) step(wr, pg, (k % period) == offset);
  endtask

  logic [2:0] dbg_idle;

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #1;
    check("rst_walk", int'(Walk), 0);
    check("rst_dont_walk", int'(Dont_Walk), 1);
    check("rst_busy", int'(Walk_Busy), 0);
    check("rst_wr_reset", int'(WR_Reset), 0);
    dbg_idle = dbg_state;
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Normal walk with grant already present, Tick every 10 cycles.
    #1; snap();
    step(1'b1, 1'b1, 1'b0);           // edge n
    #1;
    check("a_busy_n", int'(Walk_Busy), 1);
    check("a_walk_n", int'(Walk), 0);
    step(1'b1, 1'b1, 1'b0);           // edge n+1
    #1;
    check("a_walk_n1", int'(Walk), 1);
    check("a_wrr_n1", int'(WR_Reset), 1);
    check("a_dw_n1", int'(Dont_Walk), 0);
    check("a_dbg_walk_distinct", int'(dbg_state != dbg_idle), 1);
    step(1'b0, 1'b1, 1'b0);           // edge n+2
    #1;
    check("a_wrr_n2", int'(WR_Reset), 0);
    run_ticks(125, 1'b0, 1'b1, 10, 9);
    #1;
    check("a_walk_cycles", mon_walk_cyc - s_walk_cyc, 71);
    check("a_busy_cycles", mon_busy_cyc - s_busy_cyc, 122);
    check("a_wrr_pulses", mon_wrr - s_wrr, 1);
    check("a_dw_falls", mon_dw_fall - s_dw_fall, 3);
    check("a_end_busy", int'(Walk_Busy), 0);
    check("a_end_dw", int'(Dont_Walk), 1);

    // Grant withheld for 50 cycles with Ticks present, then grant dropped
    // again immediately after the walk starts.
    #1; snap();
    run_ticks(50, 1'b1, 1'b0, 10, 3);
    #1;
    check("b_wait_busy", int'(Walk_Busy), 1);
    check("b_wait_walk", int'(Walk), 0);
    check("b_wait_no_wrr", mon_wrr - s_wrr, 0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("b_grant_walk", int'(Walk), 1);
    check("b_grant_wrr", int'(WR_Reset), 1);
    snap();
    run_ticks(130, 1'b0, 1'b0, 10, 5);
    #1;
    check("b_walk_ticks", mon_walk_tick - s_walk_tick, 7);
    check("b_flash_ticks", mon_flash_tick - s_flash_tick, 5);
    check("b_busy_cycles", mon_busy_cyc - s_busy_cyc, 116);
    check("b_busy_falls", mon_busy_fall - s_busy_fall, 1);

    // Second press latched during FLASH; exactly one extra walk.
    #1; snap();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_ticks(75, 1'b0, 1'b1, 10, 9);
    #1;
    check("d_in_flash", int'(Walk_Busy && !Walk), 1);
    run_ticks(60, 1'b1, 1'b1, 10, 4);
    run_ticks(150, 1'b0, 1'b1, 10, 9);
    #1;
    check("d_wrr_pulses", mon_wrr - s_wrr, 2);
    check("d_walk_entries", mon_walk_rise - s_walk_rise, 2);
    check("d_busy_falls", mon_busy_fall - s_busy_fall, 2);

    // Ticks coincident with WALK entry and FLASH entry are ignored.
    #1; snap();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);           // tick in WALK entry cycle
    run_ticks(69, 1'b0, 1'b1, 10, 9); // six counted ticks
    #1;
    check("e_walk_after_6", int'(Walk), 1);
    step(1'b0, 1'b1, 1'b1);           // seventh counted tick
    #1;
    check("e_flash_walk", int'(Walk), 0);
    check("e_flash_dw", int'(Dont_Walk), 1);
    step(1'b0, 1'b1, 1'b1);           // tick in FLASH entry cycle
    #1;
    check("e_flash_entry_tick", int'(Dont_Walk), 1);
    snap();
    run_ticks(60, 1'b0, 1'b1, 10, 9);
    #1;
    check("e_flash_falls", mon_dw_fall - s_dw_fall, 2);
    check("e_end_busy", int'(Walk_Busy), 0);

    // Reset in the middle of WALK.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_ticks(25, 1'b0, 1'b1, 10, 9);
    #1;
    check("r_pre_walk", int'(Walk), 1);
    Reset = 1'b1;
    #1;
    check("r_walk", int'(Walk), 0);
    check("r_dw", int'(Dont_Walk), 1);
    check("r_busy", int'(Walk_Busy), 0);
    check("r_wrr", int'(WR_Reset), 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    Reset = 1'b0;
    run_ticks(20, 1'b0, 1'b1, 10, 3);
    #1;
    check("r_idle_busy", int'(Walk_Busy), 0);
    check("r_idle_dw", int'(Dont_Walk), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
